// File: rtl/uart_block_tx.sv
// Serialises a multi-byte block onto a UART line as 8N1 frames.
// Byte 0 is the most significant byte and goes first; bits within a byte go LSB first.
module uart_block_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int NUM_BYTES    = 16,
  parameter int GAP_BITS     = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [8*NUM_BYTES-1:0]                               block_in,
  input  logic                                                 block_valid,
  output logic                                                 block_ready,
  output logic                                                 tx,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [((NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1)-1:0] byte_idx
);

  localparam int BLK_W  = 8 * NUM_BYTES;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_block_tx: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [7:0]         nextByte;
  logic               baudEnd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign baudEnd = (baud_q == BAUD_LAST);

  // The current byte always sits at the top of the shift register; it moves up by a byte per frame.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        gap_d  = '0;
        idx_d  = '0;
        if (block_valid && ready_q) begin
          shreg_d = block_in;
          state_d = START;
        end
      end
      START: begin
        if (baudEnd) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudEnd) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baudEnd) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q << 8;
            state_d = (GAP_BITS > 0) ? GAP : START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      GAP: begin
        if (baudEnd) begin
          baud_d = '0;
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = START;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        gap_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so that they can be registered without a cycle of lag.
  always_comb begin
    nextByte = shreg_d[BLK_W-1 -: 8];
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == IDLE);
    done_d   = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = nextByte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign block_ready = ready_q;
  assign byte_idx    = idx_q;

endmodule

// File: tb/tb_uart_block_tx.sv
// Directed bench for uart_block_tx: three instances (default timing, fast 16-byte, fast 4-byte with gaps)
// decoded by a mid-bit sampling 8N1 receiver.
module tb_uart_block_tx;

  localparam int CPB_A = 434;
  localparam int CPB_B = 8;
  localparam int CPB_C = 8;
  localparam int GAP_C = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] blkA = '0;
  logic [127:0] blkB = '0;
  logic [31:0]  blkC = '0;
  logic validA = 1'b0, validB = 1'b0, validC = 1'b0;
  logic readyA, txA, busyA, doneA;
  logic readyB, txB, busyB, doneB;
  logic readyC, txC, busyC, doneC;
  logic [3:0] idxA, idxB;
  logic [1:0] idxC;

  uart_block_tx dutA (
    .clk(clk), .rst_n(rst_n), .block_in(blkA), .block_valid(validA), .block_ready(readyA),
    .tx(txA), .busy(busyA), .done(doneA), .byte_idx(idxA));

  uart_block_tx #(.CLKS_PER_BIT(CPB_B)) dutB (
    .clk(clk), .rst_n(rst_n), .block_in(blkB), .block_valid(validB), .block_ready(readyB),
    .tx(txB), .busy(busyB), .done(doneB), .byte_idx(idxB));

  uart_block_tx #(.CLKS_PER_BIT(CPB_C), .NUM_BYTES(4), .GAP_BITS(GAP_C)) dutC (
    .clk(clk), .rst_n(rst_n), .block_in(blkC), .block_valid(validC), .block_ready(readyC),
    .tx(txC), .busy(busyC), .done(doneC), .byte_idx(idxC));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accCyc = 0;
  int sel = 0;
  int doneCntA = 0, doneCntB = 0, doneCntC = 0;
  int overlapErr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic txS, busyS, readyS, doneS;
  logic [3:0] idxS;

  always_comb begin
    case (sel)
      0:       begin txS = txA; busyS = busyA; readyS = readyA; doneS = doneA; idxS = idxA; end
      1:       begin txS = txB; busyS = busyB; readyS = readyB; doneS = doneB; idxS = idxB; end
      default: begin txS = txC; busyS = busyC; readyS = readyC; doneS = doneC; idxS = {2'b00, idxC}; end
    endcase
  end

  // Counts done pulses per instance and catches done overlapping busy.
  always @(negedge clk) begin
    if (doneA === 1'b1) doneCntA++;
    if (doneB === 1'b1) doneCntB++;
    if (doneC === 1'b1) doneCntC++;
    if ((doneA && busyA) || (doneB && busyB) || (doneC && busyC)) overlapErr++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Offers a block to instance s for exactly one accepting edge (or keeps valid up if hold).
  task automatic applyStimulus(input int s, input logic [127:0] blk, input bit hold);
    sel = s;
    @(negedge clk);
    checkOutput("ready_before_accept", readyS, 1'b1);
    case (s)
      0:       begin blkA = blk; validA = 1'b1; end
      1:       begin blkB = blk; validB = 1'b1; end
      default: begin blkC = blk[31:0]; validC = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    if (!hold) begin
      validA = 1'b0;
      validB = 1'b0;
      validC = 1'b0;
    end
    accCyc = cyc;
    checkOutput("busy_after_accept", busyS, 1'b1);
    checkOutput("ready_after_accept", readyS, 1'b0);
    checkOutput("tx_start_after_accept", txS, 1'b0);
  endtask

  // Receives one frame; returns at the negedge of its last stop-bit cycle.
  task automatic rxByte(output logic [7:0] data, output logic [9:0] bits, output int w,
                        output int lowRun, output logic [3:0] idxMid, input int cpb);
    bit seenHigh;
    w = 0;
    lowRun = 0;
    seenHigh = 1'b0;
    bits = 'x;
    idxMid = 'x;
    data = 'x;
    do begin
      @(negedge clk);
      w++;
    end while (txS !== 1'b0 && w < 40 * cpb + 50);
    if (txS !== 1'b0) begin
      checkOutput("rx_start_seen", txS, 1'b0);
      return;
    end
    for (int k = 0; k < 10 * cpb; k++) begin
      if (k > 0) @(negedge clk);
      if (!seenHigh) begin
        if (txS === 1'b0) lowRun++;
        else seenHigh = 1'b1;
      end
      if (k % cpb == cpb / 2) bits[k / cpb] = txS;
      if (k == cpb / 2) idxMid = idxS;
    end
    data = bits[8:1];
  endtask

  task automatic runBlock(input int s, input int cpb, input int nb, input int gapBits,
                          input logic [127:0] blk, input int expLat,
                          output logic [7:0] firstB, output logic [7:0] lastB,
                          output logic [9:0] lastBits, output logic [3:0] lastIdx);
    logic [7:0] d, e;
    logic [9:0] bits;
    logic [3:0] im;
    int w, lowRun, startCyc;
    firstB = 'x;
    lastB = 'x;
    lastBits = 'x;
    lastIdx = 'x;
    applyStimulus(s, blk, 1'b0);
    startCyc = accCyc;
    for (int i = 0; i < nb; i++) begin
      e = blk[8*(nb-1-i) +: 8];
      rxByte(d, bits, w, lowRun, im, cpb);
      checkOutput("rx_byte", d, e);
      checkOutput("rx_stop_bit", bits[9], 1'b1);
      checkOutput("idle_before_start", w - 1, (i == 0) ? 0 : gapBits * cpb);
      checkOutput("byte_idx", im, i);
      if (e[0]) checkOutput("start_bit_len", lowRun, cpb);
      if (i == 0) firstB = d;
      lastB = d;
      lastBits = bits;
      lastIdx = im;
    end
    @(negedge clk);
    checkOutput("done_pulse", doneS, 1'b1);
    checkOutput("done_ready", readyS, 1'b1);
    checkOutput("done_busy", busyS, 1'b0);
    checkOutput("done_tx_idle", txS, 1'b1);
    checkOutput("done_latency", cyc - startCyc, expLat);
  endtask

  typedef struct {
    logic [127:0] blk;
    logic [7:0]   expFirst;
    logic [7:0]   expLast;
    logic [9:0]   expLastBits;
    int           expLat;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [7:0] fb, lb, d;
    logic [9:0] lbits, bits;
    logic [3:0] lidx, im;
    logic [127:0] x, y, p;
    int w, lowRun, tDone, doneBefore, lowCount;

    vecs[0] = '{128'h0123456789abcdeffedcba9876543210, 8'h01, 8'h10, 10'b1000100000, 1280};
    vecs[1] = '{128'heeeeeeeeeeeeeeeeeeeeeeeeeeeeee01, 8'hee, 8'h01, 10'b1000000010, 1280};
    vecs[2] = '{128'h80000000000000000000000000000055, 8'h80, 8'h55, 10'b1010101010, 1280};

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("reset_tx", txS, 1'b1);
      checkOutput("reset_busy", busyS, 1'b0);
      checkOutput("reset_done", doneS, 1'b0);
      checkOutput("reset_ready", readyS, 1'b1);
      checkOutput("reset_idx", idxS, 4'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("post_reset_tx", txS, 1'b1);
      checkOutput("post_reset_busy", busyS, 1'b0);
      checkOutput("post_reset_ready", readyS, 1'b1);
    end

    $display("[TB] basic frame at default timing");
    runBlock(0, CPB_A, 16, 0, 128'h00112233445566778899aabbccddeeff, 69440, fb, lb, lbits, lidx);
    checkOutput("basic_first", fb, 8'h00);
    checkOutput("basic_last", lb, 8'hff);

    $display("[TB] vector table");
    for (int v = 0; v < 3; v++) begin
      runBlock(1, CPB_B, 16, 0, vecs[v].blk, vecs[v].expLat, fb, lb, lbits, lidx);
      checkOutput("vec_first", fb, vecs[v].expFirst);
      checkOutput("vec_last", lb, vecs[v].expLast);
      checkOutput("vec_last_bits", lbits, vecs[v].expLastBits);
      checkOutput("vec_last_idx", lidx, 4'd15);
    end

    $display("[TB] held valid and block_in change mid-block");
    x = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    y = 128'hc001d00dcafef00dbeefface12345678;
    applyStimulus(1, x, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) blkB = y;
      rxByte(d, bits, w, lowRun, im, CPB_B);
      checkOutput("hold_first_block_byte", d, x[8*(15-i) +: 8]);
    end
    checkOutput("no_early_accept", readyS, 1'b0);
    @(negedge clk);
    checkOutput("hold_done", doneS, 1'b1);
    checkOutput("hold_done_ready", readyS, 1'b1);
    tDone = cyc;
    for (int i = 0; i < 16; i++) begin
      rxByte(d, bits, w, lowRun, im, CPB_B);
      if (i == 0) begin
        checkOutput("back_to_back_start", w, 1);
        validB = 1'b0;
      end
      checkOutput("hold_second_block_byte", d, y[8*(15-i) +: 8]);
    end
    @(negedge clk);
    checkOutput("second_done", doneS, 1'b1);
    checkOutput("second_done_latency", cyc - (tDone + 1), 1280);

    $display("[TB] reset during byte 5");
    p = 128'hdeadbeef0badf00d5555aaaa12481248;
    applyStimulus(1, p, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rxByte(d, bits, w, lowRun, im, CPB_B);
      checkOutput("abort_block_byte", d, p[8*(15-i) +: 8]);
    end
    repeat (4 * CPB_B + 1) @(negedge clk);
    checkOutput("abort_idx_before", idxS, 4'd5);
    doneBefore = doneCntB;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", txS, 1'b1);
    checkOutput("abort_ready", readyS, 1'b1);
    checkOutput("abort_busy", busyS, 1'b0);
    checkOutput("abort_done", doneS, 1'b0);
    checkOutput("abort_idx", idxS, 4'd0);
    lowCount = 0;
    repeat (30 * CPB_B) begin
      @(negedge clk);
      if (txS !== 1'b1) lowCount++;
    end
    checkOutput("abort_line_idle", lowCount, 0);
    checkOutput("abort_no_done", doneCntB, doneBefore);
    runBlock(1, CPB_B, 16, 0, 128'h7e7e7e7e000000ff81818181c3c3c3c3, 1280, fb, lb, lbits, lidx);
    checkOutput("after_abort_first", fb, 8'h7e);
    checkOutput("after_abort_last", lb, 8'hc3);

    $display("[TB] inter-byte gap");
    runBlock(2, CPB_C, 4, GAP_C, {96'h0, 32'ha5c30f81}, 368, fb, lb, lbits, lidx);
    checkOutput("gap_first", fb, 8'ha5);
    checkOutput("gap_last", lb, 8'h81);
    checkOutput("gap_last_idx", lidx, 4'd3);

    repeat (5) @(negedge clk);
    checkOutput("done_count_a", doneCntA, 1);
    checkOutput("done_count_b", doneCntB, 6);
    checkOutput("done_count_c", doneCntC, 1);
    checkOutput("done_busy_overlap", overlapErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
